hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Scoreboard-based hazard and flush controller for the ARM five-stage pipeline. Sits beside the ID stage and its pipeline register.
- Tracks in-flight register writes from issue in ID to retirement in WB.
- Asserts `hazard` to stall ID/IF while an operand is not yet written back.
- Sequences multi-cycle flushes after a taken branch.
- Keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles `flush` is held after a taken branch (1..7).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- src1  in  4  first source register (Rn) of the ID instruction.
- src2  in  4  second source register (Rm / Rd for STR) of the ID instruction.
- Two_src  in  1  `src2` is a live operand.
- Dest_id  in  4  destination register of the ID instruction.
- WB_EN_id  in  1  the ID instruction writes `Dest_id`.
- branch_taken  in  1  EXE stage resolved a taken branch this cycle.
- writeBackEn  in  1  WB stage writes a register this cycle.
- Dest_wb  in  4  register written by WB.
- hazard  out  1  stall: hold PC and IF/ID, insert bubble into ID/EXE.
- flush  out  1  squash IF/ID and ID/EXE contents.
- busy_mask  out  16  bit r = 1 while register r has a pending write (registered).
- stall_cnt  out  CNT_W  cycles with `hazard`=1, saturating.
- flush_cnt  out  CNT_W  taken branches accepted, saturating.

## Operation
- Scoreboard: 16 x 2-bit pending counters `pend[r]`; `busy_mask[r]` = (`pend[r]` != 0), sourced from registers.
- issue = `id_valid` & `WB_EN_id` & ~`hazard` & ~`flush`.
- retire = `writeBackEn`.
- Per cycle, for each register r: `pend[r]` += (issue & `Dest_id`==r) - (retire & `Dest_wb`==r).
  - Simultaneous issue and retire on the same r: no change.
  - Retire when `pend[r]`==0: ignored, stays 0, no underflow.
- Hazard, combinational, forced 0 while `flush`=1: `id_valid` & ( `pend[src1]`!=0 | (`Two_src` & `pend[src2]`!=0) | (`WB_EN_id` & `pend[Dest_id]`==3) ).
  - The last term is a structural stall on counter saturation.
- Same-cycle bypass: hazard uses the registered `pend`. A register retiring this cycle still stalls ID; the stall clears the next cycle.
- Flush FSM:
  - RUN:
    - `flush` = `branch_taken`.
    - If `branch_taken` and FLUSH_CYCLES>1: go to HOLD with `fcnt` = FLUSH_CYCLES-2.
  - HOLD:
    - `flush`=1; `branch_taken` is ignored.
    - If `fcnt`==0: go to RUN; else `fcnt` -= 1.
- `flush_cnt` += 1 on each `branch_taken` accepted in RUN.
- `stall_cnt` += 1 each cycle `hazard`=1.
- Both counters saturate at all-ones.

## Timing
- Reset (async, immediate):
  - all `pend`=0, `busy_mask`=0.
  - FSM=RUN, `fcnt`=0.
  - `stall_cnt`=0, `flush_cnt`=0.
  - `hazard`=0, `flush`=0 provided inputs are low.
- Reset mid-flush or mid-stall: everything clears; no pending state survives.
- `hazard`/`flush` are combinational from inputs and state, valid in the same cycle.
- Scoreboard, `busy_mask` and counters update one cycle after issue/retire.
- Latency for a dependent instruction: writer issues in cycle T. The dependent stalls until the cycle after the writer's WB cycle.
- Flush window: cycles T..T+FLUSH_CYCLES-1, where T is the `branch_taken` cycle.

## Test plan
- Back-to-back RAW:
  - Stimulus: issue R3 write in cycle 1; next cycle present `src1`=3, `id_valid`=1; retire R3 in cycle 4.
  - Required: `hazard`=1 in cycles 2-4, 0 in cycle 5; `stall_cnt`=3; `busy_mask`[3] falls in cycle 5.
- Two_src gating:
  - Stimulus: `pend[7]`!=0 with `src2`=7.
  - Required: `Two_src`=0 gives `hazard`=0; `Two_src`=1 gives `hazard`=1.
- Simultaneous issue and retire on R5 with `pend[5]`=1:
  - Required: `pend[5]` stays 1; `busy_mask`[5] stays 1.
  - Spurious retire of R9 with `pend[9]`=0: `busy_mask`=0x0000 and no wrap.
- Saturation:
  - Stimulus: three issues to R2 with no retire, then a fourth R2 writer in ID.
  - Required: `hazard`=1; `pend[2]` stays 3 until a retire.
- Flush sequencing, FLUSH_CYCLES=3:
  - Stimulus: `branch_taken` in cycle 10, again in cycle 11.
  - Required: `flush`=1 in cycles 10-12 only; `flush_cnt`=1; no issue and `hazard`=0 in 10-12 even with a RAW dependence present.
- Async reset:
  - Stimulus: assert `rst` mid-HOLD with `busy_mask`=0x0018.
  - Required: immediate `flush`=0, `busy_mask`=0, both counters 0, FSM in RUN.

Source files
------------

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: scoreboard-based RAW hazard detection plus multi-cycle
// flush sequencing for a five-stage pipeline, with saturating stall/flush
// event counters for performance debug.
module hazard_scheduler #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             Two_src,
    input  logic [3:0]       Dest_id,
    input  logic             WB_EN_id,
    input  logic             branch_taken,
    input  logic             writeBackEn,
    input  logic [3:0]       Dest_wb,
    output logic             hazard,
    output logic             flush,
    output logic [15:0]      busy_mask,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [2:0] FCNT_RELOAD =
        (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [1:0]       pend_q [16];
    logic [1:0]       pend_d [16];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             branch_accept;
    logic             issue;
    logic [15:0]      inc_vec;
    logic [15:0]      dec_vec;

    // Flush FSM: next state, flush output and branch acceptance.
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        flush         = 1'b0;
        branch_accept = 1'b0;
        case (state_q)
            RUN: begin
                flush         = branch_taken;
                branch_accept = branch_taken;
                if (branch_taken && MULTI_FLUSH) begin
                    state_d = HOLD;
                    fcnt_d  = FCNT_RELOAD;
                end
            end
            HOLD: begin
                flush = 1'b1;
                if (fcnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Hazard from registered scoreboard; the saturation term stops a fourth writer.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && !flush) begin
            hazard = (pend_q[src1] != 2'd0)
                  || (Two_src && (pend_q[src2] != 2'd0))
                  || (WB_EN_id && (pend_q[Dest_id] == 2'd3));
        end
    end

    assign issue   = id_valid & WB_EN_id & ~hazard & ~flush;
    assign inc_vec = issue       ? (16'd1 << Dest_id) : '0;
    assign dec_vec = writeBackEn ? (16'd1 << Dest_wb) : '0;

    // Scoreboard update: issue and retire on the same register cancel out.
    always_comb begin
        for (int unsigned r = 0; r < 16; r++) begin
            pend_d[r]    = pend_q[r];
            busy_mask[r] = (pend_q[r] != 2'd0);
            if (inc_vec[r] && !dec_vec[r] && (pend_q[r] != 2'd3)) begin
                pend_d[r] = pend_q[r] + 2'd1;
            end else if (dec_vec[r] && !inc_vec[r] && (pend_q[r] != 2'd0)) begin
                pend_d[r] = pend_q[r] - 2'd1;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_accept && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            pend_q      <= '{default: '0};
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: a per-register pending-count model and
// a flush-window countdown predict every output each cycle; literal checks
// pin the scenarios from the test plan.
module tb_hazard_scheduler;

    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, Two_src, WB_EN_id, branch_taken, writeBackEn;
    logic [3:0]    src1, src2, Dest_id, Dest_wb;
    logic          hazard, flush;
    logic [15:0]   busy_mask;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    int pend [16];
    int flush_left;
    int m_stall;
    int m_flush;

    // Sampled DUT outputs of the latest step, for literal checks
    logic        hz_s, fl_s;
    logic [15:0] bm_s;
    int          sc_s, fc_s;

    hazard_scheduler #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .Two_src(Two_src), .Dest_id(Dest_id), .WB_EN_id(WB_EN_id),
        .branch_taken(branch_taken), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
        .hazard(hazard), .flush(flush), .busy_mask(busy_mask),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) pend[r] = 0;
        flush_left = 0;
        m_stall    = 0;
        m_flush    = 0;
    endtask

    // One pipeline cycle: drive, compare against the model, advance the model.
    task automatic step(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic wben,
                        input logic bt, input logic wb, input logic [3:0] dwb);
        bit   e_flush, e_haz, e_issue;
        logic [15:0] e_busy;
        int   delta;
        @(negedge clk);
        id_valid = v; src1 = s1; src2 = s2; Two_src = two; Dest_id = d;
        WB_EN_id = wben; branch_taken = bt; writeBackEn = wb; Dest_wb = dwb;
        #1;
        e_flush = (flush_left > 0) || bt;
        e_haz   = !e_flush && v && ((pend[s1] > 0) || (two && pend[s2] > 0) ||
                                    (wben && pend[d] == 3));
        e_issue = v && wben && !e_haz && !e_flush;
        for (int r = 0; r < 16; r++) e_busy[r] = (pend[r] > 0);
        hz_s = hazard; fl_s = flush; bm_s = busy_mask;
        sc_s = int'(stall_cnt); fc_s = int'(flush_cnt);
        chk("hazard",    int'(hazard),    int'(e_haz));
        chk("flush",     int'(flush),     int'(e_flush));
        chk("busy_mask", int'(busy_mask), int'(e_busy));
        chk("stall_cnt", sc_s,            m_stall);
        chk("flush_cnt", fc_s,            m_flush);
        for (int r = 0; r < 16; r++) begin
            delta = ((e_issue && d == r) ? 1 : 0) - ((wb && dwb == r) ? 1 : 0);
            if (delta > 0 && pend[r] < 3) pend[r]++;
            if (delta < 0 && pend[r] > 0) pend[r]--;
        end
        if (e_haz && m_stall < SMAX) m_stall++;
        if (flush_left > 0) begin
            flush_left--;
        end else if (bt) begin
            if (m_flush < SMAX) m_flush++;
            flush_left = FC - 1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; src1 = 0; src2 = 0; Two_src = 0; Dest_id = 0;
        WB_EN_id = 0; branch_taken = 0; writeBackEn = 0; Dest_wb = 0;
        model_reset();
        #1;
        chk("rst_hazard", int'(hazard), 0);
        chk("rst_flush",  int'(flush), 0);
        chk("rst_busy",   int'(busy_mask), 0);
        chk("rst_scnt",   int'(stall_cnt), 0);
        chk("rst_fcnt",   int'(flush_cnt), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle();

        // Back-to-back RAW on R3
        step(1, 0, 0, 0, 3, 1, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);  chk("raw_c2", int'(hz_s), 1);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);  chk("raw_c3", int'(hz_s), 1);
        step(1, 3, 0, 0, 0, 0, 0, 1, 3);  chk("raw_c4", int'(hz_s), 1);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);  chk("raw_c5", int'(hz_s), 0);
        chk("raw_scnt", sc_s, 3);
        chk("raw_busy3", int'(bm_s[3]), 0);

        // Two_src gating on R7
        step(1, 0, 0, 0, 7, 1, 0, 0, 0);
        step(1, 0, 7, 0, 0, 0, 0, 0, 0);  chk("two0", int'(hz_s), 0);
        step(1, 0, 7, 1, 0, 0, 0, 0, 0);  chk("two1", int'(hz_s), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 7);

        // Simultaneous issue/retire on R5, then spurious retire on R9
        step(1, 0, 0, 0, 5, 1, 0, 0, 0);
        step(1, 0, 0, 0, 5, 1, 0, 1, 5);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5);  chk("simul_busy", int'(bm_s), 32'h0020);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9);
        idle();                           chk("spur_busy", int'(bm_s), 0);

        // Saturation of R2 pending counter
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);  chk("sat_haz", int'(hz_s), 1);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);  chk("sat_haz2", int'(hz_s), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 2);
        idle();                           chk("sat_drain", int'(bm_s), 0);

        // Flush window with a RAW dependence present
        step(1, 0, 0, 0, 4, 1, 0, 0, 0);
        step(1, 4, 0, 0, 6, 1, 1, 0, 0);  chk("fl_t0", int'(fl_s), 1); chk("fl_t0_hz", int'(hz_s), 0);
        step(1, 4, 0, 0, 6, 1, 1, 0, 0);  chk("fl_t1", int'(fl_s), 1); chk("fl_t1_hz", int'(hz_s), 0);
        step(1, 4, 0, 0, 6, 1, 0, 0, 0);  chk("fl_t2", int'(fl_s), 1); chk("fl_t2_hz", int'(hz_s), 0);
        step(1, 4, 0, 0, 6, 1, 0, 0, 0);  chk("fl_t3", int'(fl_s), 0); chk("fl_t3_hz", int'(hz_s), 1);
        chk("fl_busy", int'(bm_s), 32'h0010);
        chk("fl_cnt", fc_s, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 4);

        // Stall counter saturation
        step(1, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();                           chk("scnt_sat", sc_s, SMAX);

        // Async reset in the middle of a flush hold
        step(1, 0, 0, 0, 3, 1, 0, 0, 0);
        step(1, 0, 0, 0, 4, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);  chk("pre_rst_busy", int'(bm_s), 32'h0018);
        @(negedge clk);
        branch_taken = 0;
        #2;
        chk("hold_flush", int'(flush), 1);
        rst = 1'b1;
        #1;
        chk("arst_flush", int'(flush), 0);
        chk("arst_busy",  int'(busy_mask), 0);
        chk("arst_scnt",  int'(stall_cnt), 0);
        chk("arst_fcnt",  int'(flush_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();                           chk("post_rst_flush", int'(fl_s), 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        idle();
        idle();                           chk("post_rst_run", int'(fl_s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
